// File: rtl/div_arbiter_if.sv
// Bundle of the two requester channels, the divider port and the response channels.
// The arbiter uses the slave modport; the master modport is the environment side.
interface div_arbiter_if #(
   parameter int unsigned TAGW = 4
);
   logic            req0_valid;
   logic            req0_ready;
   logic [31:0]     req0_dividend;
   logic [15:0]     req0_divisor;
   logic [TAGW-1:0] req0_tag;
   logic            req1_valid;
   logic            req1_ready;
   logic [31:0]     req1_dividend;
   logic [15:0]     req1_divisor;
   logic [TAGW-1:0] req1_tag;

   logic            div_ctrl;
   logic [31:0]     div_dividend;
   logic [15:0]     div_divisor;
   logic [31:0]     div_answer;
   logic            div_exception;
   logic            div_rdy;

   logic            rsp0_valid;
   logic [31:0]     rsp0_answer;
   logic            rsp0_exception;
   logic [TAGW-1:0] rsp0_tag;
   logic            rsp1_valid;
   logic [31:0]     rsp1_answer;
   logic            rsp1_exception;
   logic [TAGW-1:0] rsp1_tag;

   logic            sync_err;

   modport slave (
      input  req0_valid, req0_dividend, req0_divisor, req0_tag,
      input  req1_valid, req1_dividend, req1_divisor, req1_tag,
      input  div_answer, div_exception, div_rdy,
      output req0_ready, req1_ready,
      output div_ctrl, div_dividend, div_divisor,
      output rsp0_valid, rsp0_answer, rsp0_exception, rsp0_tag,
      output rsp1_valid, rsp1_answer, rsp1_exception, rsp1_tag,
      output sync_err
   );

   modport master (
      output req0_valid, req0_dividend, req0_divisor, req0_tag,
      output req1_valid, req1_dividend, req1_divisor, req1_tag,
      output div_answer, div_exception, div_rdy,
      input  req0_ready, req1_ready,
      input  div_ctrl, div_dividend, div_divisor,
      input  rsp0_valid, rsp0_answer, rsp0_exception, rsp0_tag,
      input  rsp1_valid, rsp1_answer, rsp1_exception, rsp1_tag,
      input  sync_err
   );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin front end for a fixed-latency divider shared by two requesters.
// A shadow tracker routes each result home and flags divider/tracker desync.
module div_arbiter #(
   parameter int unsigned LATENCY = 35,
   parameter int unsigned TAGW    = 4,
   parameter int unsigned MAXOUT  = 8
) (
   input logic          clk_i,
   input logic          rst_ni,
   div_arbiter_if.slave bus_io
);

   localparam int unsigned CntW = $clog2(MAXOUT + 1);
   localparam int unsigned WuW  = $clog2(LATENCY + 1);
   localparam int unsigned EntW = TAGW + 2;

   logic [CntW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [WuW-1:0]  wu_q, wu_d;
   logic            rr_q, rr_d;
   logic            sync_err_q, sync_err_d;
   logic [EntW-1:0] trk_q [LATENCY];
   logic [EntW-1:0] trk_d, trk_out;
   logic            elig0, elig1, gnt0, gnt1;
   logic            out_vld, rsp0, rsp1, warm;

   always_comb begin
      elig0 = bus_io.req0_valid && (cnt0_q < CntW'(MAXOUT));
      elig1 = bus_io.req1_valid && (cnt1_q < CntW'(MAXOUT));
      gnt0  = elig0 && (!elig1 || !rr_q);
      gnt1  = elig1 && (!elig0 || rr_q);

      rr_d = rr_q;
      if (gnt0) begin
         rr_d = 1'b1;
      end else if (gnt1) begin
         rr_d = 1'b0;
      end

      bus_io.req0_ready   = gnt0;
      bus_io.req1_ready   = gnt1;
      bus_io.div_ctrl     = gnt0 | gnt1;
      bus_io.div_dividend = '0;
      bus_io.div_divisor  = '0;
      trk_d               = '0;
      if (gnt0) begin
         bus_io.div_dividend = bus_io.req0_dividend;
         bus_io.div_divisor  = bus_io.req0_divisor;
         trk_d               = {1'b1, 1'b0, bus_io.req0_tag};
      end else if (gnt1) begin
         bus_io.div_dividend = bus_io.req1_dividend;
         bus_io.div_divisor  = bus_io.req1_divisor;
         trk_d               = {1'b1, 1'b1, bus_io.req1_tag};
      end

      // Responses come from the tracker alone; div_rdy only feeds the desync check.
      trk_out = trk_q[LATENCY-1];
      out_vld = trk_out[TAGW+1];
      rsp0    = out_vld && !trk_out[TAGW];
      rsp1    = out_vld && trk_out[TAGW];

      bus_io.rsp0_valid     = rsp0;
      bus_io.rsp0_answer    = rsp0 ? bus_io.div_answer : '0;
      bus_io.rsp0_exception = rsp0 && bus_io.div_exception;
      bus_io.rsp0_tag       = rsp0 ? trk_out[TAGW-1:0] : '0;
      bus_io.rsp1_valid     = rsp1;
      bus_io.rsp1_answer    = rsp1 ? bus_io.div_answer : '0;
      bus_io.rsp1_exception = rsp1 && bus_io.div_exception;
      bus_io.rsp1_tag       = rsp1 ? trk_out[TAGW-1:0] : '0;

      cnt0_d = cnt0_q;
      if (gnt0 && !rsp0) begin
         cnt0_d = cnt0_q + CntW'(1);
      end else if (!gnt0 && rsp0) begin
         cnt0_d = cnt0_q - CntW'(1);
      end
      cnt1_d = cnt1_q;
      if (gnt1 && !rsp1) begin
         cnt1_d = cnt1_q + CntW'(1);
      end else if (!gnt1 && rsp1) begin
         cnt1_d = cnt1_q - CntW'(1);
      end

      // Stale divider results from before reset drain out during warm-up.
      warm       = (wu_q == WuW'(LATENCY));
      wu_d       = warm ? wu_q : wu_q + WuW'(1);
      sync_err_d = sync_err_q || (warm && (bus_io.div_rdy != out_vld));
      bus_io.sync_err = sync_err_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            trk_q[i] <= '0;
         end
         cnt0_q     <= '0;
         cnt1_q     <= '0;
         wu_q       <= '0;
         rr_q       <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         trk_q[0] <= trk_d;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            trk_q[i] <= trk_q[i-1];
         end
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
         wu_q       <= wu_d;
         rr_q       <= rr_d;
         sync_err_q <= sync_err_d;
      end
   end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter LATENCY, default 35, SHALL set the divider issue-to-result latency in clock cycles.
REQ-002 Parameter TAGW, default 4, SHALL set the requester tag width.
REQ-003 Parameter MAXOUT, default 8, SHALL set the maximum in-flight operations per requester.
REQ-004 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 reqN_valid  input  1  (N=0,1) SHALL mean requester N presents a divide.
REQ-007 reqN_ready  output  1  SHALL mean requester N is granted this cycle.
REQ-008 reqN_dividend  input  32  SHALL be the signed dividend.
REQ-009 reqN_divisor  input  16  SHALL be the signed divisor.
REQ-010 reqN_tag  input  TAGW  SHALL be the requester's opaque tag.
REQ-011 div_ctrl  output  1  SHALL be the divider start strobe (ctrl_DIV).
REQ-012 div_dividend  output  32 and div_divisor  output  16  SHALL be the divider operands.
REQ-013 div_answer  input  32, div_exception  input  1, div_rdy  input  1  SHALL be the divider result, divide-by-zero flag and result_RDY.
REQ-014 rspN_valid  output  1  SHALL be a one-cycle response pulse to requester N.
REQ-015 rspN_answer  output  32, rspN_exception  output  1, rspN_tag  output  TAGW  SHALL be the response payload.
REQ-016 sync_err  output  1  SHALL flag a sticky divider/tracker mismatch.

Function
REQ-017 Requester N SHALL be eligible iff reqN_valid=1 and its outstanding count < MAXOUT.
REQ-018 Arbitration SHALL be round-robin: if both are eligible, the requester selected by pointer rr is granted; if only one is eligible, that one is granted.
REQ-019 rr SHALL toggle to the non-granted requester on every grant, and SHALL hold when no grant occurs.
REQ-020 reqN_ready SHALL be combinational and equal to the grant for N; at most one grant per cycle; acceptance means valid&ready in the same cycle.
REQ-021 In the grant cycle, div_ctrl SHALL be 1 and div_dividend/div_divisor SHALL carry the granted operands; otherwise div_ctrl=0 and both operands SHALL be 0.
REQ-022 A LATENCY-deep tracker shift register SHALL carry {valid, requester id, tag}, loading one entry per cycle (valid=0 when no grant).
REQ-023 rspN_valid SHALL pulse exactly LATENCY cycles after acceptance when the tracker output entry is valid with id N; rspN_answer=div_answer, rspN_exception=div_exception, rspN_tag=stored tag in that cycle.
REQ-024 When rspN_valid=0, rspN_answer, rspN_exception and rspN_tag SHALL be 0.
REQ-025 Responses SHALL never be backpressured; per-requester response order SHALL equal acceptance order.
REQ-026 Outstanding count N SHALL increment on acceptance for N and decrement on rspN_valid; both in the same cycle SHALL leave it unchanged; range 0..MAXOUT.
REQ-027 A warm-up counter SHALL run for LATENCY cycles after reset release; during warm-up, mismatch detection SHALL be masked while grants proceed normally.
REQ-028 After warm-up, sync_err SHALL set on the next edge whenever div_rdy differs from the tracker output valid bit; once set it SHALL hold until reset.
REQ-029 Responses SHALL be generated from the tracker only; div_rdy SHALL never create a response.

Reset
REQ-030 Reset assertion SHALL immediately clear the tracker, both outstanding counts, sync_err and all rsp outputs, set rr=0 and restart warm-up.
REQ-031 Operations in flight at reset SHALL never produce responses, even though the divider pipeline itself is not reset.

Verification
REQ-032 After reset and warm-up, req0 100/7 tag 3 -> exactly 35 cycles later rsp0_valid=1, answer=14, tag=3, exception=0; -100/7 -> answer 0xFFFFFFF2.
REQ-033 Both requesters valid continuously from reset release -> grants in order 0,1,0,1,... and responses in the same order, 35 cycles after each grant.
REQ-034 req1 5/0 tag 9 -> rsp1_valid with exception=1, tag=9.
REQ-035 req0 valid held 50 cycles alone -> 8 back-to-back accepts, then ready=0 until cycle 35, then one accept per response.
REQ-036 Reset pulsed with 3 ops in flight -> no rsp pulses follow, counts=0, and sync_err stays 0 despite stale div_rdy pulses.
REQ-037 After warm-up, force div_rdy=1 with an empty tracker -> sync_err=1 on the next edge and held until reset.
